// File: rtl/march_pkg.sv
// Shared types for the March C- element engine: element codes,
// phase constants, FSM states and the per-element pattern lookup.
package march_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4
  } elem_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  localparam logic [4:0] PH_RD  = 5'd0;
  localparam logic [4:0] PH_CMP = 5'd1;
  localparam logic [4:0] PH_WR  = 5'd2;

  typedef struct packed {
    logic down;
    logic rw;
    logic rd1;
    logic wr1;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(elem_e e);
    elem_cfg_t c;
    c = '{down: 1'b1, rw: 1'b0, rd1: 1'b0, wr1: 1'b0};
    case (e)
      M0: c = '{down: 1'b1, rw: 1'b0, rd1: 1'b0, wr1: 1'b0};
      M1: c = '{down: 1'b0, rw: 1'b1, rd1: 1'b0, wr1: 1'b1};
      M2: c = '{down: 1'b0, rw: 1'b1, rd1: 1'b1, wr1: 1'b0};
      M3: c = '{down: 1'b1, rw: 1'b1, rd1: 1'b0, wr1: 1'b1};
      M4: c = '{down: 1'b1, rw: 1'b1, rd1: 1'b1, wr1: 1'b0};
      default: c = '{down: 1'b1, rw: 1'b0, rd1: 1'b0, wr1: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/march_element_engine_addr_gen.sv
// Loadable up/down address counter with terminal-address detect.
// Never wraps: stepping at the end address is the caller's problem.
module march_addr_gen
  import march_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_down,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_at_end
);

  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_down ? '1 : '0;
    end else if (i_step) begin
      r_addr <= i_down ? r_addr - 1'b1 : r_addr + 1'b1;
    end
  end

  assign o_addr   = r_addr;
  assign o_at_end = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/march_element_engine.sv
// March C- element engine: walks the address space per element,
// issues read/compare/write ops and keeps a sticky first-fail record.
module march_element_engine
  import march_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en1,
  input  logic                  en2,
  input  logic                  en3,
  input  logic                  en4,
  input  logic                  finish,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [4:0]            counter,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  elem_done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  state_e                r_state;
  state_e                w_next;
  elem_e                 r_elem;
  elem_e                 w_sel;
  logic [4:0]            r_cnt;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;

  elem_cfg_t             w_cfg;
  elem_cfg_t             w_sel_cfg;
  logic                  w_req;
  logic                  w_en_cur;
  logic                  w_last_ph;
  logic                  w_at_end;
  logic                  w_load;
  logic                  w_step;
  logic                  w_down;
  logic                  w_adv;
  logic                  w_miss;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_req     = start | en1 | en2 | en3 | en4;
  assign w_cfg     = elem_cfg(r_elem);
  assign w_sel_cfg = elem_cfg(w_sel);

  always_comb begin
    w_sel = M0;
    if (start)    w_sel = M0;
    else if (en1) w_sel = M1;
    else if (en2) w_sel = M2;
    else if (en3) w_sel = M3;
    else if (en4) w_sel = M4;
  end

  always_comb begin
    w_en_cur = 1'b0;
    case (r_elem)
      M0: w_en_cur = start;
      M1: w_en_cur = en1;
      M2: w_en_cur = en2;
      M3: w_en_cur = en3;
      M4: w_en_cur = en4;
      default: w_en_cur = 1'b0;
    endcase
  end

  assign w_last_ph = w_cfg.rw ? (r_cnt == PH_WR) : 1'b1;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_en_cur) begin
          w_next = S_IDLE;
        end else begin
          w_adv = 1'b1;
          if (w_last_ph && w_at_end) w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_WAIT;
      S_WAIT: begin
        if (!w_en_cur) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_step = w_adv && w_last_ph && !w_at_end;
  assign w_down = w_load ? w_sel_cfg.down : w_cfg.down;

  march_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_down  (w_down),
    .o_addr  (w_addr),
    .o_at_end(w_at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_elem  <= M0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_elem <= w_sel;
        r_cnt  <= '0;
      end else if (w_adv) begin
        r_cnt <= (w_cfg.rw && !w_last_ph) ? r_cnt + 5'd1 : 5'd0;
      end
    end
  end

  // Read data lands one cycle after the read strobe, i.e. in PH_CMP.
  assign w_miss = (r_state == S_RUN) && w_cfg.rw && (r_cnt == PH_CMP) &&
                  (mem_rdata != {DATA_WIDTH{w_cfg.rd1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
    end else if (!finish) begin
      if (w_load && w_sel == M0) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
      end else if (w_miss && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_addr;
        r_fail_elem <= r_elem;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign elem_done = (r_state == S_DONE);
  assign mem_re    = busy && w_cfg.rw && (r_cnt == PH_RD);
  assign mem_we    = busy && (w_cfg.rw ? (r_cnt == PH_WR) : 1'b1);
  assign mem_wdata = mem_we ? {DATA_WIDTH{w_cfg.wr1}} : '0;
  assign address   = w_addr;
  assign mem_addr  = w_addr;
  assign counter   = r_cnt;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_march_element_engine.sv
// Directed bench for march_element_engine, ADDR_WIDTH=4, with a
// 1-cycle-latency SRAM model and an optional stuck-at-1 bit.
module tb_march_element_engine;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, en1, en2, en3, en4, finish;
  logic [AW-1:0] address;
  logic [4:0]    counter;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, elem_done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  logic [DW-1:0] mem [16];
  logic          stuck;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  march_element_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .en1      (en1),
    .en2      (en2),
    .en3      (en3),
    .en4      (en4),
    .finish   (finish),
    .address  (address),
    .counter  (counter),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .elem_done(elem_done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re)
      mem_rdata <= mem[mem_addr] |
        ((stuck && mem_addr == 4'd5) ? 8'h01 : 8'h00);
  end

  task automatic set_en(input int idx, input logic v);
    case (idx)
      0: start = v;
      1: en1   = v;
      2: en2   = v;
      3: en3   = v;
      4: en4   = v;
      default: ;
    endcase
  endtask

  task automatic run_elem(input int idx, output int done_c,
                          output int fail_c);
    @(negedge clk);
    set_en(idx, 1'b1);
    done_c = -1;
    fail_c = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (fail && fail_c < 0) fail_c = c;
      if (elem_done) begin
        done_c = c;
        break;
      end
    end
    set_en(idx, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (done_c < 0) begin
      bad++;
      $display("FAIL run_elem%0d: elem_done not seen in 200 cycles", idx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {start, en1, en2, en3, en4, finish} = '0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, elem_done, mem_we, mem_re, fail} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, elem_done, mem_we, mem_re, fail});
    end
    total++;
    if ({address, counter, mem_wdata, fail_addr, fail_elem} !== '0) begin
      bad++;
      $display("FAIL reset_values: addr=%0d cnt=%0d wdata=%h want 0",
               address, counter, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_m0;
    int writes, errs, done_c, pulses;
    logic [AW-1:0] exp_a;
    writes = 0; errs = 0; done_c = -1; pulses = 0;
    exp_a = 4'd15;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (mem_addr !== exp_a || mem_wdata !== 8'h00 || mem_re) errs++;
        exp_a = exp_a - 1'b1;
        writes++;
      end
      if (elem_done) begin
        pulses++;
        if (done_c < 0) done_c = c;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (writes !== 16) begin
      bad++;
      $display("FAIL m0_writes: got %0d want 16", writes);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL m0_write_seq: %0d bad writes want 0", errs);
    end
    total++;
    if (done_c !== 17 || pulses !== 1) begin
      bad++;
      $display("FAIL m0_done: cycle=%0d pulses=%0d want 17/1",
               done_c, pulses);
    end
    total++;
    if (fail !== 1'b0) begin
      bad++;
      $display("FAIL m0_fail: got %b want 0", fail);
    end
  endtask

  task automatic test_m1;
    int errs, done_c, pulses;
    int ph;
    errs = 0; done_c = -1; pulses = 0;
    @(negedge clk);
    en1 = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (c <= 48) begin
        ph = (c - 1) % 3;
        if (counter !== 5'(ph)) errs++;
        if (address !== 4'((c - 1) / 3)) errs++;
        if (busy !== 1'b1) errs++;
        if (mem_re !== (ph == 0)) errs++;
        if (mem_we !== (ph == 2)) errs++;
        if (ph == 2 && mem_wdata !== 8'hFF) errs++;
      end
      if (elem_done) begin
        pulses++;
        if (done_c < 0) done_c = c;
      end
    end
    en1 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL m1_sequence: %0d cycle errors want 0", errs);
    end
    total++;
    if (done_c !== 49 || pulses !== 1) begin
      bad++;
      $display("FAIL m1_done: cycle=%0d pulses=%0d want 49/1",
               done_c, pulses);
    end
    total++;
    if (fail !== 1'b0 || mem[7] !== 8'hFF) begin
      bad++;
      $display("FAIL m1_result: fail=%b mem7=%h want 0/ff", fail, mem[7]);
    end
  endtask

  task automatic test_stuck;
    int dc, fc;
    stuck = 1'b1;
    run_elem(0, dc, fc);
    run_elem(1, dc, fc);
    total++;
    if (fc !== 18) begin
      bad++;
      $display("FAIL stuck_fail_cycle: got %0d want 18", fc);
    end
    total++;
    if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_elem !== 3'd1) begin
      bad++;
      $display("FAIL stuck_record: fail=%b addr=%0d elem=%0d want 1/5/1",
               fail, fail_addr, fail_elem);
    end
    run_elem(2, dc, fc);
    run_elem(3, dc, fc);
    run_elem(4, dc, fc);
    total++;
    if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_elem !== 3'd1) begin
      bad++;
      $display("FAIL stuck_sticky: fail=%b addr=%0d elem=%0d want 1/5/1",
               fail, fail_addr, fail_elem);
    end
  endtask

  task automatic test_abort;
    int hit, dones;
    hit = -1; dones = 0;
    @(negedge clk);
    en3 = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy && address == 4'd9) begin
        hit = c;
        break;
      end
    end
    en3 = 1'b0;
    @(negedge clk);
    total++;
    if (hit !== 19) begin
      bad++;
      $display("FAIL abort_reach9: cycle=%0d want 19", hit);
    end
    total++;
    if ({busy, mem_we, mem_re} !== 3'b000) begin
      bad++;
      $display("FAIL abort_outputs: busy/we/re=%b want 000",
               {busy, mem_we, mem_re});
    end
    for (int c = 0; c < 6; c++) begin
      if (elem_done) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: pulses=%0d want 0", dones);
    end
  endtask

  task automatic test_priority;
    int done_c;
    done_c = -1;
    @(negedge clk);
    start = 1'b1;
    en2   = 1'b1;
    @(negedge clk);
    total++;
    if (!(busy === 1'b1 && address === 4'd15 && mem_we === 1'b1 &&
          mem_wdata === 8'h00 && mem_re === 1'b0)) begin
      bad++;
      $display("FAIL prio_m0: busy=%b addr=%0d we=%b re=%b want 1/15/1/0",
               busy, address, mem_we, mem_re);
    end
    total++;
    if (fail !== 1'b0) begin
      bad++;
      $display("FAIL prio_clear: fail=%b want 0", fail);
    end
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (elem_done) begin
        done_c = c;
        break;
      end
    end
    start = 1'b0;
    en2   = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (done_c !== 17) begin
      bad++;
      $display("FAIL prio_done: cycle=%0d want 17", done_c);
    end
  endtask

  task automatic test_reset_mid;
    int dc, fc;
    run_elem(0, dc, fc);
    run_elem(1, dc, fc);
    total++;
    if (fail !== 1'b1) begin
      bad++;
      $display("FAIL rmid_setup: fail=%b want 1", fail);
    end
    @(negedge clk);
    en2 = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, mem_we, mem_re, elem_done} !== 4'b0 ||
        address !== '0 || counter !== '0) begin
      bad++;
      $display("FAIL rmid_outputs: busy=%b we=%b re=%b addr=%0d cnt=%0d",
               busy, mem_we, mem_re, address, counter);
    end
    total++;
    if (fail !== 1'b0 || fail_addr !== '0 || fail_elem !== '0) begin
      bad++;
      $display("FAIL rmid_record: fail=%b addr=%0d elem=%0d want 0",
               fail, fail_addr, fail_elem);
    end
    en2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    run_elem(0, dc, fc);
    total++;
    if (dc !== 17 || fail !== 1'b0 || mem[3] !== 8'h00) begin
      bad++;
      $display("FAIL rmid_rerun: done=%0d fail=%b mem3=%h want 17/0/00",
               dc, fail, mem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_m0();
    test_m1();
    test_stuck();
    test_abort();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
